// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// It runs one shift-add or restoring-divide step per cycle, then applies a sign fix-up cycle.
module mips_muldiv #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(6'b011000);
  localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);
  localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(6'b011010);
  localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(6'b011011);
  localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(6'b010001);
  localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(6'b010011);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NB_CNT-1:0]       r_cnt;
  logic [2*NB_DATA-1:0]    r_acc;
  logic [NB_DATA-1:0]      r_opb;
  logic                    r_is_div;
  logic                    r_sgn_q;
  logic                    r_sgn_r;
  logic [NB_DATA-1:0]      r_hi;
  logic [NB_DATA-1:0]      r_lo;
  logic                    r_done;

  logic                    w_idle;
  logic                    w_is_mul;
  logic                    w_is_div;
  logic                    w_signed;
  logic                    w_accept;
  logic                    w_mthi;
  logic                    w_mtlo;
  logic                    w_sgn_a;
  logic                    w_sgn_b;
  logic [NB_DATA-1:0]      w_mag_a;
  logic [NB_DATA-1:0]      w_mag_b;
  logic [NB_DATA:0]        w_mul_sum;
  logic [NB_DATA:0]        w_div_shift;
  logic [NB_DATA+1:0]      w_div_diff;
  logic [2*NB_DATA-1:0]    w_acc_nxt;
  logic [2*NB_DATA-1:0]    w_prod;
  logic [NB_DATA-1:0]      w_hi_fix;
  logic [NB_DATA-1:0]      w_lo_fix;

  function automatic logic [NB_DATA-1:0] f_abs(input logic signed [NB_DATA-1:0] v,
                                               input logic                      is_signed);
    if (is_signed && (v < 0)) return -v;
    return v;
  endfunction

  function automatic logic [NB_DATA-1:0] f_fix_n(input logic [NB_DATA-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*NB_DATA-1:0] f_fix_2n(input logic [2*NB_DATA-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_accept = w_idle && i_start && (w_is_mul || w_is_div);
  assign w_mthi   = w_idle && i_start && (i_op == OP_MTHI);
  assign w_mtlo   = w_idle && i_start && (i_op == OP_MTLO);
  assign w_sgn_a  = w_signed && i_datoA[NB_DATA-1];
  assign w_sgn_b  = w_signed && i_datoB[NB_DATA-1];
  assign w_mag_a  = f_abs(i_datoA, w_signed);
  assign w_mag_b  = f_abs(i_datoB, w_signed);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == NB_CNT'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration: multiply adds into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_div_shift = r_acc[2*NB_DATA-1:NB_DATA-1];
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    if (r_is_div) begin
      if (!w_div_diff[NB_DATA+1]) w_acc_nxt = {w_div_diff[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b1};
      else                        w_acc_nxt = {w_div_shift[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0};
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[NB_DATA-1:1]};
    end
  end

  always_comb begin
    w_prod = f_fix_2n(r_acc, r_sgn_q);
    if (r_is_div) begin
      w_hi_fix = f_fix_n(r_acc[2*NB_DATA-1:NB_DATA], r_sgn_r);
      w_lo_fix = f_fix_n(r_acc[NB_DATA-1:0], r_sgn_q);
    end else begin
      w_hi_fix = w_prod[2*NB_DATA-1:NB_DATA];
      w_lo_fix = w_prod[NB_DATA-1:0];
    end
  end

  // Operand capture at the accepting edge; the accumulator holds {0, multiplier} or {0, dividend}.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_acc    <= {{NB_DATA{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_opb    <= w_is_div ? w_mag_b : w_mag_a;
      r_is_div <= w_is_div;
      r_sgn_q  <= w_sgn_a ^ w_sgn_b;
      r_sgn_r  <= w_sgn_a;
    end else if (r_state == S_CALC) begin
      r_acc    <= w_acc_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_cnt <= NB_CNT'(NB_DATA);
          if (w_mthi) begin
            r_hi   <= i_datoA;
            r_done <= 1'b1;
          end
          if (w_mtlo) begin
            r_lo   <= i_datoA;
            r_done <= 1'b1;
          end
        end
        S_CALC: r_cnt <= r_cnt - NB_CNT'(1);
        S_FIX: begin
          r_hi   <= w_hi_fix;
          r_lo   <= w_lo_fix;
          r_done <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = ~w_idle;
  assign o_done = r_done;

endmodule
